// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU between two valid/ready requesters,
// with a one-entry tagged response register. Optional perf counters: ALU_ARB_PERF_EN.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_src_a,
    input  logic [WIDTH-1:0] req0_src_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_src_a,
    input  logic [WIDTH-1:0] req1_src_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]      perf_grant0,
    output logic [15:0]      perf_grant1,
    output logic [15:0]      perf_stall
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       last_grant;
    logic       slot_free_c;
    logic       grant0_c;
    logic       grant1_c;
    logic       accept_c;

    // Grant: the requester that did not win last time has priority on a tie
    always_comb begin
        slot_free_c = (state == EMPTY) | rsp_ready;
        grant0_c    = slot_free_c & req0_valid & (~req1_valid | last_grant);
        grant1_c    = slot_free_c & req1_valid & (~req0_valid | ~last_grant);
        accept_c    = grant0_c | grant1_c;
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;

    // Granted operands steer the ALU; idle drive is all-zero
    always_comb begin
        alu_src_a = '0;
        alu_src_b = '0;
        alu_op    = '0;
        if (grant0_c) begin
            alu_src_a = req0_src_a;
            alu_src_b = req0_src_b;
            alu_op    = req0_op;
        end else if (grant1_c) begin
            alu_src_a = req1_src_a;
            alu_src_b = req1_src_b;
            alu_op    = req1_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Response slot: an accept always (re)fills it, a drain without accept empties it
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept_c) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept_c) begin
                    state_nxt = FULL;
                end else if (rsp_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept_c) begin
            rsp_id     <= grant1_c;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            last_grant <= grant1_c;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic stall_c;
    assign stall_c = (req0_valid | req1_valid) & ~accept_c;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= 16'd0;
            perf_grant1 <= 16'd0;
            perf_stall  <= 16'd0;
        end else begin
            if (grant0_c && perf_grant0 != 16'hFFFF) begin
                perf_grant0 <= perf_grant0 + 16'd1;
            end
            if (grant1_c && perf_grant1 != 16'hFFFF) begin
                perf_grant1 <= perf_grant1 + 16'd1;
            end
            if (stall_c && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the bench also plays the role of the external ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_src_a, req0_src_b, req1_src_a, req1_src_b;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [31:0] alu_src_a, alu_src_b, alu_result, rsp_result;
    logic        alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_src_a(req0_src_a), .req0_src_b(req0_src_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_src_a(req1_src_a), .req1_src_b(req1_src_b), .req1_op(req1_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    // External ALU
    always_comb begin
        case (alu_op)
            4'b0010: alu_result = alu_src_a + alu_src_b;
            4'b0110: alu_result = alu_src_a - alu_src_b;
            4'b0000: alu_result = alu_src_a & alu_src_b;
            4'b0001: alu_result = alu_src_a | alu_src_b;
            4'b1010: alu_result = alu_src_a ^ alu_src_b;
            4'b1000: alu_result = alu_src_a << alu_src_b[4:0];
            4'b1001: alu_result = alu_src_a >> alu_src_b[4:0];
            4'b0111: alu_result = 32'($signed(alu_src_a) < $signed(alu_src_b));
            4'b1111: alu_result = 32'(alu_src_a < alu_src_b);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_src_a = '0; req0_src_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_src_a = '0; req1_src_b = '0; req1_op = '0;
        rsp_ready = 1'b1;
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("idle_alu_a", alu_src_a, 32'd0);
        check("idle_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single ADD
        @(negedge clk);
        req0_valid = 1'b1; req0_src_a = 32'd1; req0_src_b = 32'd1; req0_op = 4'b0010;
        #1;
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_alu_a", alu_src_a, 32'd1);
        check("t1_alu_op", 32'(alu_op), 32'h2);
        tick();
        req0_valid = 1'b0;
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_result", rsp_result, 32'd2);
        check("t1_rsp_zero", 32'(rsp_zero), 32'd0);
        tick();
        check("t1_drain", 32'(rsp_valid), 32'd0);

        // 2: contention after reset, req0 first then req1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_src_a = 32'd2; req0_src_b = 32'd1; req0_op = 4'b0110;
        req1_valid = 1'b1; req1_src_a = 32'd0; req1_src_b = 32'hFFFF_FFFF; req1_op = 4'b1010;
        #1;
        check("t2_ready0", 32'(req0_ready), 32'd1);
        check("t2_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("t2_rsp0_id", 32'(rsp_id), 32'd0);
        check("t2_rsp0_result", rsp_result, 32'd1);
        check("t2_ready1_b", 32'(req1_ready), 32'd1);
        check("t2_alu_b", alu_src_b, 32'hFFFF_FFFF);
        tick();
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        check("t2_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp1_id", 32'(rsp_id), 32'd1);
        check("t2_rsp1_result", rsp_result, 32'hFFFF_FFFF);

        // 3: backpressure holds response and blocks grant
        req1_valid = 1'b1; req1_src_a = 32'd1; req1_src_b = 32'd2; req1_op = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_ready1_blocked", 32'(req1_ready), 32'd0);
            check("t3_rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("t3_rsp_result_hold", rsp_result, 32'hFFFF_FFFF);
            check("t3_rsp_id_hold", 32'(rsp_id), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("t3_ready1_drain", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("t3_rsp_id", 32'(rsp_id), 32'd1);
        check("t3_rsp_result", rsp_result, 32'd1);

        // 4: zero flag from SUB and SLTU
        req1_valid = 1'b1; req1_src_a = 32'd5; req1_src_b = 32'd5; req1_op = 4'b0110;
        tick();
        req1_valid = 1'b0;
        check("t4_sub_id", 32'(rsp_id), 32'd1);
        check("t4_sub_result", rsp_result, 32'd0);
        check("t4_sub_zero", 32'(rsp_zero), 32'd1);
        req0_valid = 1'b1; req0_src_a = 32'd2; req0_src_b = 32'd1; req0_op = 4'b1111;
        tick();
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        check("t4_sltu_id", 32'(rsp_id), 32'd0);
        check("t4_sltu_result", rsp_result, 32'd0);
        check("t4_sltu_zero", 32'(rsp_zero), 32'd1);

        // 5: async reset mid-response, then req0 wins despite req0 being last
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(rsp_valid), 32'd0);
        check("t5_async_zero", 32'(rsp_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_src_a = 32'h0000_00F0; req0_src_b = 32'h0000_000F; req0_op = 4'b0001;
        req1_valid = 1'b1; req1_src_a = 32'd1; req1_src_b = 32'd4; req1_op = 4'b1000;
        #1;
        check("t5_ready0", 32'(req0_ready), 32'd1);
        check("t5_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("t5_rsp0_id", 32'(rsp_id), 32'd0);
        check("t5_rsp0_result", rsp_result, 32'h0000_00FF);
        tick();
        req1_valid = 1'b0;
        check("t5_rsp1_id", 32'(rsp_id), 32'd1);
        check("t5_rsp1_result", rsp_result, 32'd16);

`ifdef ALU_ARB_PERF_EN
        // 6: counters and saturation
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("t6_rst_grant0", 32'(perf_grant0), 32'd0);
        req0_valid = 1'b1; req0_src_a = 32'd3; req0_src_b = 32'd4; req0_op = 4'b0010;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        repeat (2) tick();
        check("t6_grant0", 32'(perf_grant0), 32'd3);
        check("t6_grant1", 32'(perf_grant1), 32'd0);
        check("t6_stall", 32'(perf_stall), 32'd2);
        repeat (70000) @(posedge clk);
        #1;
        check("t6_stall_sat", 32'(perf_stall), 32'h0000_FFFF);
        req0_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
